// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter, round-robin on contention.
// Define SRAM_ARB_FIXED_PRIO_EN to make requester 0 always win instead.
module sram_arbiter #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req0,
    input  logic               i_req1,
    input  logic               i_we0,
    input  logic               i_we1,
    input  logic [BW_ADDR-1:0] i_addr0,
    input  logic [BW_ADDR-1:0] i_addr1,
    input  logic [BW_DATA-1:0] i_wdata0,
    input  logic [BW_DATA-1:0] i_wdata1,
    output logic               o_gnt0,
    output logic               o_gnt1,
    output logic               o_rvalid0,
    output logic               o_rvalid1,
    output logic [BW_DATA-1:0] o_rdata,
    output logic               o_cen,
    output logic               o_wen,
    output logic               o_oen,
    output logic [BW_ADDR-1:0] o_addr,
    output logic [BW_DATA-1:0] o_wdata,
    input  logic [BW_DATA-1:0] i_rdata
);

    logic gnt0;
    logic gnt1;
    logic prefer1;
    logic rvalid0_q;
    logic rvalid1_q;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign prefer1 = 1'b0;
`else
    logic ptr;

    // Priority pointer moves to whichever requester lost this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

    assign prefer1 = ptr;
`endif

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (i_req0 && (!i_req1 || !prefer1)) begin
                gnt0 = 1'b1;
            end else if (i_req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign o_gnt0 = gnt0;
    assign o_gnt1 = gnt1;

    // SRAM pin drive from the granted requester, idle otherwise
    always_comb begin
        o_cen   = 1'b1;
        o_wen   = 1'b1;
        o_oen   = 1'b1;
        o_addr  = '0;
        o_wdata = '0;
        if (gnt0) begin
            o_cen   = 1'b0;
            o_wen   = ~i_we0;
            o_oen   = i_we0;
            o_addr  = i_addr0;
            o_wdata = i_wdata0;
        end else if (gnt1) begin
            o_cen   = 1'b0;
            o_wen   = ~i_we1;
            o_oen   = i_we1;
            o_addr  = i_addr1;
            o_wdata = i_wdata1;
        end
    end

    // Remember who owns the read data returning next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~i_we0;
            rvalid1_q <= gnt1 & ~i_we1;
        end
    end

    // A read in flight when reset arrives is dropped immediately
    assign o_rvalid0 = rvalid0_q & ~rst;
    assign o_rvalid1 = rvalid1_q & ~rst;

    assign o_rdata = (o_rvalid0 | o_rvalid1) ? i_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table plus read-data
// scoreboard, with a behavioural SRAM hanging off the pins.
module tb_sram_arbiter;

    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 5;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               i_req0, i_req1, i_we0, i_we1;
    logic [BW_ADDR-1:0] i_addr0, i_addr1;
    logic [BW_DATA-1:0] i_wdata0, i_wdata1;
    logic               o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
    logic [BW_DATA-1:0] o_rdata;
    logic               o_cen, o_wen, o_oen;
    logic [BW_ADDR-1:0] o_addr;
    logic [BW_DATA-1:0] o_wdata;
    logic [BW_DATA-1:0] i_rdata;

    sram_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
        .clk(clk), .rst(rst),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_we0(i_we0), .i_we1(i_we1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata(o_rdata),
        .o_cen(o_cen), .o_wen(o_wen), .o_oen(o_oen),
        .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    logic [BW_DATA-1:0] mem [32];
    logic [BW_DATA-1:0] model_mem [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'hA5A5_0000 | i;
            model_mem[i] = 32'hA5A5_0000 | i;
        end
        i_rdata = '0;
    end

    always @(posedge clk) begin
        if (!o_cen && !o_wen) mem[o_addr] <= o_wdata;
        if (!o_cen && o_wen) i_rdata <= mem[o_addr];
    end

    typedef struct {
        logic               rst;
        logic               req0, req1, we0, we1;
        logic [BW_ADDR-1:0] addr0, addr1;
        logic [BW_DATA-1:0] wdata0, wdata1;
        logic               g0, g1;
    } vec_t;

    typedef struct {
        logic               v;
        logic               who;
        logic [BW_DATA-1:0] d;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic r, input logic q0, input logic q1,
        input logic w0, input logic w1,
        input logic [BW_ADDR-1:0] a0, input logic [BW_ADDR-1:0] a1,
        input logic [BW_DATA-1:0] d0, input logic [BW_DATA-1:0] d1,
        input logic g0, input logic g1);
        vec_t v;
        v.rst = r; v.req0 = q0; v.req1 = q1; v.we0 = w0; v.we1 = w1;
        v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [BW_DATA-1:0] act,
                       input logic [BW_DATA-1:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        sb_t e;
        logic               g;
        logic               w;
        logic [BW_ADDR-1:0] a;
        logic [BW_DATA-1:0] d;
        @(posedge clk);
        #1;
        rst = v.rst;
        i_req0 = v.req0; i_req1 = v.req1;
        i_we0 = v.we0; i_we1 = v.we1;
        i_addr0 = v.addr0; i_addr1 = v.addr1;
        i_wdata0 = v.wdata0; i_wdata1 = v.wdata1;
        @(negedge clk);
        n_vec++;
        g = v.g0 | v.g1;
        w = v.g0 ? v.we0 : v.we1;
        a = v.g0 ? v.addr0 : v.addr1;
        d = v.g0 ? v.wdata0 : v.wdata1;
        chk("gnt0", idx, 32'(o_gnt0), 32'(v.g0));
        chk("gnt1", idx, 32'(o_gnt1), 32'(v.g1));
        chk("cen", idx, 32'(o_cen), 32'(!g));
        chk("wen", idx, 32'(o_wen), 32'(!(g && w)));
        chk("oen", idx, 32'(o_oen), 32'(!(g && !w)));
        chk("addr", idx, 32'(o_addr), g ? 32'(a) : 32'd0);
        chk("wdata", idx, o_wdata, g ? d : 32'd0);
        e.v = 1'b0; e.who = 1'b0; e.d = '0;
        if (sb.size() > 0) e = sb.pop_front();
        if (v.rst) e.v = 1'b0;
        chk("rvalid0", idx, 32'(o_rvalid0), 32'(e.v && !e.who));
        chk("rvalid1", idx, 32'(o_rvalid1), 32'(e.v && e.who));
        chk("rdata", idx, o_rdata, e.v ? e.d : 32'd0);
        e.v = g && !w && !v.rst;
        e.who = v.g1;
        e.d = model_mem[a];
        sb.push_back(e);
        if (g && w && !v.rst) model_mem[a] = d;
    endtask

    initial begin
        rst = 1'b1;
        i_req0 = 0; i_req1 = 0; i_we0 = 0; i_we1 = 0;
        i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;

        // reset held with live requests: no grants
        vecs.push_back(mk(1,1,1,0,0,5'h01,5'h02,0,0,0,0));
        vecs.push_back(mk(1,1,1,1,1,5'h01,5'h02,1,2,0,0));
        // contention right after reset: 0,1,0,1 (fixed: 0,0,0,0)
        vecs.push_back(mk(0,1,1,0,0,5'h01,5'h02,32'h0BAD_0000,0,1,0));
        vecs.push_back(mk(0,1,1,0,0,5'h01,5'h02,32'h0BAD_0000,0,FIXED,!FIXED));
        vecs.push_back(mk(0,1,1,0,0,5'h01,5'h02,32'h0BAD_0000,0,1,0));
        vecs.push_back(mk(0,1,1,0,0,5'h01,5'h02,32'h0BAD_0000,0,FIXED,!FIXED));
        // idle
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,0,0,5'h07,5'h09,5,6,0,0));
        // single read of 0x03
        vecs.push_back(mk(0,1,0,0,0,5'h03,5'h00,0,0,1,0));
        // requester 1 writes, requester 0 reads it back
        vecs.push_back(mk(0,0,1,0,1,5'h00,5'h11,0,32'hDEAD_BEEF,0,1));
        vecs.push_back(mk(0,1,0,0,0,5'h11,5'h00,0,0,1,0));
        // back-to-back reads; loser keeps requesting
        vecs.push_back(mk(0,1,1,0,0,5'h00,5'h10,0,0,FIXED,!FIXED));
        vecs.push_back(mk(0,!FIXED,FIXED,0,0,5'h00,5'h10,0,0,!FIXED,FIXED));
        vecs.push_back(mk(0,0,0,0,0,5'h00,5'h00,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,5'h00,5'h00,0,0,0,0));
        // read then reset in flight; next contest goes to 0
        vecs.push_back(mk(0,1,0,0,0,5'h05,5'h00,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,5'h05,5'h06,0,0,0,0));
        vecs.push_back(mk(0,1,1,1,1,5'h0A,5'h0B,32'h1,32'h2,1,0));
        vecs.push_back(mk(0,0,0,0,0,5'h00,5'h00,0,0,0,0));
        // withdrawn request never wins
        vecs.push_back(mk(0,0,1,0,0,5'h00,5'h0A,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,5'h00,5'h00,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
